frontend_cu: RTL and testbench
==============================

Name: frontend_cu

Overview:
- Control-unit end of the parallel channel: the counterpart of the channel-side frontend that drives the "A" channel tags.
- Receives the channel's outbound tags and bus through the inverting line receivers, and runs the initial-selection and ending-status (reconnect) sequences.
- Registers drivers for the inbound tags and bus.
- Hands commands and status to a device core over simple valid/ready strobes.

Parameters:
DEVICE_ADDRESS, 8'h10, device address this CU answers to (exact match on bus_out).

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  0: CU detached; select passes through, all other drivers quiet
c_bus_out_n  in  8  channel bus out, active-low from receivers
c_operational_out_n  in  1  tag, active-low
c_select_out_n  in  1  tag, active-low
c_hold_out_n  in  1  tag, active-low
c_address_out_n  in  1  tag, active-low
c_command_out_n  in  1  tag, active-low
c_service_out_n  in  1  tag, active-low
c_suppress_out_n  in  1  tag, active-low
c_bus_in  out  8  bus in to drivers, active-high
c_operational_in, c_request_in, c_select_in, c_address_in, c_status_in, c_service_in  out  1 each  tags to drivers, active-high
driver_enable  out  1  inbound driver enable
cmd_valid  out  1  one-cycle pulse: cmd_byte holds a new command
cmd_byte  out  8  command latched from bus_out
stat_valid  in  1  core presents initial status
stat_byte  in  8  initial status byte
end_valid  in  1  core offers ending status
end_status  in  8  ending status byte
end_ready  out  1  CU can accept ending status; end_valid&end_ready loads the pending buffer
end_done  out  1  one-cycle pulse: channel accepted the pending ending status

Behaviour:
- Synchronisers: every *_n input goes through a 2FF synchroniser, then is inverted; all names below refer to synced active-high values. Synchroniser flops reset to 1, i.e. tag inactive.
- Outputs: all outputs are registered. A pin change reaches an output 3 clk later (2 sync + 1 FSM/output register).
- Reset: while reset_n=0 every output is 0; state=IDLE; pending=0; cmd_byte=0.
- Selection: sel = select_out & hold_out.
- enable=0:
  - FSM forced to IDLE; pending cleared.
  - c_select_in = select_out, so the select chain is preserved.
  - All other outputs are 0.
- operational_out=0 in any state acts as a system reset: FSM goes to IDLE, all tag, bus and strobe outputs go to 0, and pending is cleared.
- Outputs shared across states:
  - driver_enable <= enable & operational_out.
  - c_request_in = enable & pending & ~suppress_out & state==IDLE.
  - end_ready = enable & ~pending.
- FSM states:
  - IDLE, all tags 0. On sel rising edge:
    - address_out & bus_out==DEVICE_ADDRESS: reselect flag resel=0, go to ADDRESS.
    - else ~address_out & c_request_in: resel=1, go to ADDRESS.
    - else go to PROPAGATE.
  - PROPAGATE: c_select_in=select_out. Return to IDLE when select_out=0.
  - ADDRESS: operational_in=1, address_in=1, bus_in=DEVICE_ADDRESS. On command_out=1:
    - latch bus_out into cmd_byte (only when resel=0);
    - drop address_in; bus_in=0;
    - go to COMMAND.
  - COMMAND: wait for command_out=0.
    - resel=0: pulse cmd_valid, go to STATUS_WAIT.
    - resel=1: go to STATUS with status register = pending byte.
  - STATUS_WAIT: on stat_valid latch stat_byte, go to STATUS. stat_valid outside this state is ignored.
  - STATUS: status_in=1, bus_in=status register.
    - service_out=1 (accept): if resel, pulse end_done and clear pending. Go to DISCONNECT.
    - command_out=1 (stack): if resel, pending is kept; otherwise pending:=1 and the pending byte gets stat_byte, even if a core-loaded pending existed. Go to DISCONNECT.
    - Both tags in the same cycle: treated as accept.
  - DISCONNECT: status_in=0, bus_in=0, operational_in held. When service_out=0 and command_out=0, drop operational_in and go to IDLE.
- Pending buffer:
  - Loaded on end_valid & end_ready.
  - A load and a stack in the same cycle: the stack wins and end_ready is low next cycle.
- Suppression: suppress_out holds off c_request_in only; it never aborts a sequence in progress.
- Unused output: c_service_in is always 0 in this block; there is no data phase.

Test Plan:
- Initial selection, accept:
  - Stimulus: address_out with bus_out=8'h10, then select_out+hold_out; after address_in, command_out with bus_out=8'h02, then drop it; stat_valid with 8'h00; then service_out.
  - Required: operational_in/address_in with bus_in=8'h10 3 clk after select; cmd_valid once with cmd_byte=8'h02; status_in with bus_in=8'h00; operational_in drops after service_out drops.
- Address mismatch: bus_out=8'h11 during selection -> c_select_in follows select_out; operational_in never rises; it falls 3 clk after select_out drops.
- Ending-status reconnect:
  - Stimulus: end_valid with 8'h0C; then select_out without address_out; then command_out with bus_out=8'h00; then service_out.
  - Required: end_ready falls; request_in rises; reselection presents address 8'h10, then status_in with bus_in=8'h0C; end_done pulses once; request_in stays 0 afterwards.
- Stack: in the reconnect above, respond with command_out instead of service_out -> no end_done; request_in rises again after disconnect; a second reconnect presents 8'h0C again.
- Suppress and system reset:
  - Pending set with suppress_out=1 -> request_in=0; suppress_out released -> request_in=1.
  - Drop operational_out mid-STATUS -> all tags 0 within 3 clk and pending cleared.
  - reset_n low asynchronously mid-ADDRESS -> all outputs 0 immediately.
- enable=0 -> toggling select_out is echoed on c_select_in; every other output stays 0; driver_enable=0.

Source files
------------

// File: rtl/frontend_cu.sv
// Control-unit end of the parallel channel: synchronises the outbound tags/bus,
// runs initial selection and ending-status reconnection, and registers the inbound drivers.
module frontend_cu #(
  parameter logic [7:0] DEVICE_ADDRESS = 8'h10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [7:0] c_bus_out_n,
  input  logic       c_operational_out_n,
  input  logic       c_select_out_n,
  input  logic       c_hold_out_n,
  input  logic       c_address_out_n,
  input  logic       c_command_out_n,
  input  logic       c_service_out_n,
  input  logic       c_suppress_out_n,
  output logic [7:0] c_bus_in,
  output logic       c_operational_in,
  output logic       c_request_in,
  output logic       c_select_in,
  output logic       c_address_in,
  output logic       c_status_in,
  output logic       c_service_in,
  output logic       driver_enable,
  output logic       cmd_valid,
  output logic [7:0] cmd_byte,
  input  logic       stat_valid,
  input  logic [7:0] stat_byte,
  input  logic       end_valid,
  input  logic [7:0] end_status,
  output logic       end_ready,
  output logic       end_done,
  output logic [2:0] dbg_state
);

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_PROPAGATE   = 3'd1;
  localparam logic [2:0] S_ADDRESS     = 3'd2;
  localparam logic [2:0] S_COMMAND     = 3'd3;
  localparam logic [2:0] S_STATUS_WAIT = 3'd4;
  localparam logic [2:0] S_STATUS      = 3'd5;
  localparam logic [2:0] S_DISCONNECT  = 3'd6;

  // Synchroniser flops reset to all-ones so every tag reads inactive after reset.
  logic [14:0] meta_q, sync_q;
  logic [7:0]  bus_out;
  logic        operational_out, select_out, hold_out, address_out;
  logic        command_out, service_out, suppress_out;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= {c_bus_out_n, c_operational_out_n, c_select_out_n, c_hold_out_n,
                 c_address_out_n, c_command_out_n, c_service_out_n, c_suppress_out_n};
      sync_q <= meta_q;
    end
  end

  assign {bus_out, operational_out, select_out, hold_out, address_out,
          command_out, service_out, suppress_out} = ~sync_q;

  logic       sel, sel_prev_q, sel_rise;
  logic [2:0] state_q, state_d;
  logic       resel_q, resel_d;
  logic [7:0] status_q, status_d;
  logic [7:0] cmd_byte_q, cmd_byte_d;
  logic       pending_q, pending_d;
  logic [7:0] pend_byte_q, pend_byte_d;
  logic       cmd_valid_d, end_done_d;

  logic [7:0] bus_in_q, bus_in_d;
  logic       op_in_q, op_in_d, req_q, req_d, sel_in_q, sel_in_d;
  logic       addr_in_q, addr_in_d, status_in_q, status_in_d;
  logic       de_q, de_d, rdy_q, rdy_d, cmd_valid_q, end_done_q;

  assign sel      = select_out & hold_out;
  assign sel_rise = sel & ~sel_prev_q;

  always_comb begin
    state_d     = state_q;
    resel_d     = resel_q;
    status_d    = status_q;
    cmd_byte_d  = cmd_byte_q;
    pending_d   = pending_q;
    pend_byte_d = pend_byte_q;
    cmd_valid_d = 1'b0;
    end_done_d  = 1'b0;

    if (end_valid && rdy_q) begin
      pending_d   = 1'b1;
      pend_byte_d = end_status;
    end

    case (state_q)
      S_IDLE: begin
        if (sel_rise) begin
          if (address_out && (bus_out == DEVICE_ADDRESS)) begin
            resel_d = 1'b0;
            state_d = S_ADDRESS;
          end else if (!address_out && req_q) begin
            resel_d = 1'b1;
            state_d = S_ADDRESS;
          end else begin
            state_d = S_PROPAGATE;
          end
        end
      end
      S_PROPAGATE: if (!select_out) state_d = S_IDLE;
      S_ADDRESS: begin
        if (command_out) begin
          if (!resel_q) cmd_byte_d = bus_out;
          state_d = S_COMMAND;
        end
      end
      S_COMMAND: begin
        if (!command_out) begin
          if (resel_q) begin
            status_d = pend_byte_q;
            state_d  = S_STATUS;
          end else begin
            cmd_valid_d = 1'b1;
            state_d     = S_STATUS_WAIT;
          end
        end
      end
      S_STATUS_WAIT: begin
        if (stat_valid) begin
          status_d = stat_byte;
          state_d  = S_STATUS;
        end
      end
      S_STATUS: begin
        // Service wins over command when both arrive together.
        if (service_out) begin
          if (resel_q) begin
            end_done_d = 1'b1;
            pending_d  = 1'b0;
          end
          state_d = S_DISCONNECT;
        end else if (command_out) begin
          if (!resel_q) begin
            pending_d   = 1'b1;
            pend_byte_d = status_q;
          end
          state_d = S_DISCONNECT;
        end
      end
      S_DISCONNECT: if (!service_out && !command_out) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (!enable || !operational_out) begin
      state_d     = S_IDLE;
      pending_d   = 1'b0;
      cmd_valid_d = 1'b0;
      end_done_d  = 1'b0;
    end
  end

  // Outputs are decoded from next state so they land in the same edge as the FSM.
  // end_ready is withheld during channel system reset so no core status is silently dropped.
  always_comb begin
    op_in_d     = (state_d != S_IDLE) && (state_d != S_PROPAGATE);
    addr_in_d   = (state_d == S_ADDRESS);
    status_in_d = (state_d == S_STATUS);
    bus_in_d    = 8'h00;
    if (state_d == S_ADDRESS)     bus_in_d = DEVICE_ADDRESS;
    else if (state_d == S_STATUS) bus_in_d = status_d;
    sel_in_d    = enable ? ((state_d == S_PROPAGATE) && select_out) : select_out;
    req_d       = enable && operational_out && pending_d && !suppress_out && (state_d == S_IDLE);
    rdy_d       = enable && operational_out && !pending_d;
    de_d        = enable && operational_out;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      resel_q     <= 1'b0;
      status_q    <= 8'h00;
      cmd_byte_q  <= 8'h00;
      pending_q   <= 1'b0;
      pend_byte_q <= 8'h00;
      sel_prev_q  <= 1'b0;
      bus_in_q    <= 8'h00;
      op_in_q     <= 1'b0;
      req_q       <= 1'b0;
      sel_in_q    <= 1'b0;
      addr_in_q   <= 1'b0;
      status_in_q <= 1'b0;
      de_q        <= 1'b0;
      rdy_q       <= 1'b0;
      cmd_valid_q <= 1'b0;
      end_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      resel_q     <= resel_d;
      status_q    <= status_d;
      cmd_byte_q  <= cmd_byte_d;
      pending_q   <= pending_d;
      pend_byte_q <= pend_byte_d;
      sel_prev_q  <= sel;
      bus_in_q    <= bus_in_d;
      op_in_q     <= op_in_d;
      req_q       <= req_d;
      sel_in_q    <= sel_in_d;
      addr_in_q   <= addr_in_d;
      status_in_q <= status_in_d;
      de_q        <= de_d;
      rdy_q       <= rdy_d;
      cmd_valid_q <= cmd_valid_d;
      end_done_q  <= end_done_d;
    end
  end

  assign c_bus_in         = bus_in_q;
  assign c_operational_in = op_in_q;
  assign c_request_in     = req_q;
  assign c_select_in      = sel_in_q;
  assign c_address_in     = addr_in_q;
  assign c_status_in      = status_in_q;
  assign c_service_in     = 1'b0;
  assign driver_enable    = de_q;
  assign cmd_valid        = cmd_valid_q;
  assign cmd_byte         = cmd_byte_q;
  assign end_ready        = rdy_q;
  assign end_done         = end_done_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_frontend_cu.sv
// Directed bench for frontend_cu: stimulus pushes expected output snapshots and
// strobes into queues; a negedge monitor pops and compares whenever the DUT changes.
module tb_frontend_cu;

  // ---------------- clock / reset ----------------
  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic enable  = 1'b1;
  always #5 clk = ~clk;

  // Active-high view of channel pins; the DUT sees them inverted.
  logic [7:0] bus_out      = 8'h00;
  logic       op_out       = 1'b0;
  logic       select_out   = 1'b0;
  logic       hold_out     = 1'b0;
  logic       address_out  = 1'b0;
  logic       command_out  = 1'b0;
  logic       service_out  = 1'b0;
  logic       suppress_out = 1'b0;
  logic       stat_valid   = 1'b0;
  logic [7:0] stat_byte    = 8'h00;
  logic       end_valid    = 1'b0;
  logic [7:0] end_status   = 8'h00;

  logic [7:0] c_bus_in, cmd_byte;
  logic       c_operational_in, c_request_in, c_select_in, c_address_in, c_status_in, c_service_in;
  logic       driver_enable, cmd_valid, end_ready, end_done;
  logic [2:0] dbg_state;

  frontend_cu #(.DEVICE_ADDRESS(8'h10)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .enable              (enable),
    .c_bus_out_n         (~bus_out),
    .c_operational_out_n (~op_out),
    .c_select_out_n      (~select_out),
    .c_hold_out_n        (~hold_out),
    .c_address_out_n     (~address_out),
    .c_command_out_n     (~command_out),
    .c_service_out_n     (~service_out),
    .c_suppress_out_n    (~suppress_out),
    .c_bus_in            (c_bus_in),
    .c_operational_in    (c_operational_in),
    .c_request_in        (c_request_in),
    .c_select_in         (c_select_in),
    .c_address_in        (c_address_in),
    .c_status_in         (c_status_in),
    .c_service_in        (c_service_in),
    .driver_enable       (driver_enable),
    .cmd_valid           (cmd_valid),
    .cmd_byte            (cmd_byte),
    .stat_valid          (stat_valid),
    .stat_byte           (stat_byte),
    .end_valid           (end_valid),
    .end_status          (end_status),
    .end_ready           (end_ready),
    .end_done            (end_done),
    .dbg_state           (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [15:0] vec;
  assign vec = {driver_enable, c_operational_in, c_request_in, c_select_in, c_address_in,
                c_status_in, c_service_in, end_ready, c_bus_in};

  logic [15:0] exp_q[$];
  logic [7:0]  exp_cmd_q[$];
  logic        exp_done_q[$];
  logic [15:0] last_vec = 16'h0000;
  logic [15:0] exp_v;
  logic [7:0]  exp_c;
  logic        mon_en = 1'b0;
  int          n_vec  = 0;
  int          n_fail = 0;

  function automatic logic [15:0] sv(input logic de, op, req, sel, adr, st, rdy, input logic [7:0] bus);
    return {de, op, req, sel, adr, st, 1'b0, rdy, bus};
  endfunction

  localparam logic [15:0] IDLE_ON = 16'h8100;

  always @(negedge clk) begin
    if (mon_en) begin
      if (vec !== last_vec) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL outputs: got %h, required no change from %h", vec, last_vec);
        end else begin
          exp_v = exp_q.pop_front();
          if (vec !== exp_v) begin
            n_fail++;
            $display("FAIL outputs: got %h, required %h", vec, exp_v);
          end
        end
        last_vec = vec;
      end
      if (cmd_valid) begin
        n_vec++;
        if (exp_cmd_q.size() == 0) begin
          n_fail++;
          $display("FAIL cmd_valid: got pulse with %h, required none", cmd_byte);
        end else begin
          exp_c = exp_cmd_q.pop_front();
          if (cmd_byte !== exp_c) begin
            n_fail++;
            $display("FAIL cmd_byte: got %h, required %h", cmd_byte, exp_c);
          end
        end
      end
      if (end_done) begin
        n_vec++;
        if (exp_done_q.size() == 0) begin
          n_fail++;
          $display("FAIL end_done: got pulse, required none");
        end else begin
          void'(exp_done_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while ((exp_q.size() + exp_cmd_q.size() + exp_done_q.size()) != 0 && t < 40) begin
      cyc(1);
      t++;
    end
    n_vec++;
    if (t >= 40) begin
      n_fail++;
      $display("FAIL %s: got %0d events still pending, required 0", name,
               exp_q.size() + exp_cmd_q.size() + exp_done_q.size());
      exp_q.delete();
      exp_cmd_q.delete();
      exp_done_q.delete();
    end
    cyc(4);
  endtask

  task automatic lat(input string name, input bit use_sel, input logic val, input int want);
    int c = 0;
    do begin
      cyc(1);
      c++;
    end while (((use_sel ? c_select_in : c_operational_in) !== val) && c < 10);
    n_vec++;
    if (c != want) begin
      n_fail++;
      $display("FAIL %s latency: got %0d clk, required %0d", name, c, want);
    end
  endtask

  task automatic chk_zero(input string name);
    n_vec++;
    if ({vec, cmd_valid, end_done, cmd_byte, dbg_state} !== 29'h0) begin
      n_fail++;
      $display("FAIL %s: got %h, required 0", name, {vec, cmd_valid, end_done, cmd_byte, dbg_state});
    end
  endtask

  task automatic sel_pins(input logic v);
    select_out = v;
    hold_out   = v;
  endtask

  task automatic stat(input logic [7:0] b);
    stat_byte  = b;
    stat_valid = 1'b1;
    cyc(1);
    stat_valid = 1'b0;
  endtask

  task automatic load_end(input logic [7:0] b);
    end_status = b;
    end_valid  = 1'b1;
    for (int i = 0; i < 20 && !end_ready; i++) cyc(1);
    cyc(1);
    end_valid = 1'b0;
  endtask

  // Addressed initial selection, command, initial status; leaves the DUT in STATUS.
  task automatic select_dev(input logic [7:0] cmd, input logic [7:0] st);
    address_out = 1'b1; bus_out = 8'h10; cyc(2);
    exp_q.push_back(sv(1,1,0,0,1,0,1,8'h10));
    sel_pins(1'b1);
    lat("select_to_operational_in", 1'b0, 1'b1, 3);
    drain("sel_address");
    exp_q.push_back(sv(1,1,0,0,0,0,1,8'h00));
    address_out = 1'b0; command_out = 1'b1; bus_out = cmd;
    drain("sel_command");
    exp_cmd_q.push_back(cmd);
    command_out = 1'b0; bus_out = 8'h00;
    drain("sel_cmd_valid");
    exp_q.push_back(sv(1,1,0,0,0,1,1,st));
    stat(st);
    drain("sel_status");
  endtask

  // Reselection via request_in; leaves the DUT in STATUS presenting the pending byte.
  task automatic resel_to_status(input logic [7:0] st);
    exp_q.push_back(sv(1,1,0,0,1,0,0,8'h10));
    sel_pins(1'b1);
    drain("resel_address");
    exp_q.push_back(sv(1,1,0,0,0,0,0,8'h00));
    command_out = 1'b1;
    drain("resel_command");
    exp_q.push_back(sv(1,1,0,0,0,1,0,st));
    command_out = 1'b0;
    drain("resel_status");
  endtask

  task automatic resel_accept();
    exp_done_q.push_back(1'b1);
    exp_q.push_back(sv(1,1,0,0,0,0,1,8'h00));
    service_out = 1'b1;
    drain("resel_accept");
    exp_q.push_back(IDLE_ON);
    service_out = 1'b0;
    drain("resel_idle");
    sel_pins(1'b0); cyc(4);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    cyc(3);
    chk_zero("reset");
    reset_n = 1'b1; cyc(4);
    mon_en = 1'b1;
    exp_q.push_back(IDLE_ON);
    op_out = 1'b1;
    drain("operational_up");

    // Initial selection, accepted.
    select_dev(8'h02, 8'h00);
    exp_q.push_back(sv(1,1,0,0,0,0,1,8'h00));
    service_out = 1'b1;
    drain("t1_disconnect");
    exp_q.push_back(IDLE_ON);
    service_out = 1'b0;
    lat("service_drop_to_operational_in", 1'b0, 1'b0, 3);
    drain("t1_idle");
    sel_pins(1'b0); cyc(4);

    // Address mismatch: select propagates.
    address_out = 1'b1; bus_out = 8'h11; cyc(2);
    exp_q.push_back(sv(1,0,0,1,0,0,1,8'h00));
    sel_pins(1'b1);
    drain("t2_propagate");
    exp_q.push_back(IDLE_ON);
    select_out = 1'b0;
    lat("select_drop_to_select_in", 1'b1, 1'b0, 3);
    drain("t2_idle");
    hold_out = 1'b0; address_out = 1'b0; bus_out = 8'h00; cyc(4);

    // Ending-status reconnect, accepted.
    exp_q.push_back(sv(1,0,1,0,0,0,0,8'h00));
    load_end(8'h0C);
    drain("t3_load");
    resel_to_status(8'h0C);
    resel_accept();

    // Reconnect stacked, then presented again and accepted.
    exp_q.push_back(sv(1,0,1,0,0,0,0,8'h00));
    load_end(8'h0C);
    drain("t4_load");
    resel_to_status(8'h0C);
    exp_q.push_back(sv(1,1,0,0,0,0,0,8'h00));
    command_out = 1'b1;
    drain("t4_stack");
    exp_q.push_back(sv(1,0,1,0,0,0,0,8'h00));
    command_out = 1'b0;
    drain("t4_request_again");
    sel_pins(1'b0); cyc(4);
    resel_to_status(8'h0C);
    resel_accept();

    // Initial status stacked by the channel becomes the pending byte.
    select_dev(8'h07, 8'h5A);
    exp_q.push_back(sv(1,1,0,0,0,0,0,8'h00));
    command_out = 1'b1;
    drain("t5_stack");
    exp_q.push_back(sv(1,0,1,0,0,0,0,8'h00));
    command_out = 1'b0;
    drain("t5_request");
    sel_pins(1'b0); cyc(4);
    resel_to_status(8'h5A);
    resel_accept();

    // Suppress holds off request; operational_out drop mid-STATUS clears everything.
    suppress_out = 1'b1; cyc(4);
    exp_q.push_back(sv(1,0,0,0,0,0,0,8'h00));
    load_end(8'h0C);
    drain("t6_suppressed");
    exp_q.push_back(sv(1,0,1,0,0,0,0,8'h00));
    suppress_out = 1'b0;
    drain("t6_released");
    resel_to_status(8'h0C);
    exp_q.push_back(16'h0000);
    op_out = 1'b0;
    lat("operational_drop_to_operational_in", 1'b0, 1'b0, 3);
    drain("t6_system_reset");
    sel_pins(1'b0); cyc(3);
    exp_q.push_back(IDLE_ON);
    op_out = 1'b1;
    drain("t6_pending_cleared");

    // Asynchronous reset in ADDRESS.
    address_out = 1'b1; bus_out = 8'h10; cyc(2);
    exp_q.push_back(sv(1,1,0,0,1,0,1,8'h10));
    sel_pins(1'b1);
    drain("t7_address");
    exp_q.push_back(16'h0000);
    #3 reset_n = 1'b0;
    #1 chk_zero("async_reset");
    sel_pins(1'b0); address_out = 1'b0; bus_out = 8'h00; cyc(3);
    exp_q.push_back(IDLE_ON);
    reset_n = 1'b1;
    drain("t7_recover");

    // Detached: select echoes, everything else quiet, no pending load.
    exp_q.push_back(16'h0000);
    enable = 1'b0;
    drain("t8_detach");
    end_status = 8'h33; end_valid = 1'b1; cyc(3); end_valid = 1'b0;
    exp_q.push_back(sv(0,0,0,1,0,0,0,8'h00));
    address_out = 1'b1; bus_out = 8'h10;
    sel_pins(1'b1);
    lat("detached_select_rise", 1'b1, 1'b1, 3);
    drain("t8_echo_rise");
    exp_q.push_back(16'h0000);
    select_out = 1'b0;
    lat("detached_select_fall", 1'b1, 1'b0, 3);
    drain("t8_echo_fall");
    hold_out = 1'b0; address_out = 1'b0; bus_out = 8'h00; cyc(3);
    exp_q.push_back(IDLE_ON);
    enable = 1'b1;
    drain("t8_reattach");

    n_vec++;
    if ((exp_q.size() + exp_cmd_q.size() + exp_done_q.size()) != 0) begin
      n_fail++;
      $display("FAIL leftover: got %0d expected events unmatched, required 0",
               exp_q.size() + exp_cmd_q.size() + exp_done_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog");
  end

endmodule
